decoder_3to8: RTL and testbench

DECODER_3TO8 -- requirements
Module: decoder_3to8

---
 rtl/decoder_3to8_if.sv | 12 +
 rtl/decoder_3to8.sv | 22 ++
 tb/tb_decoder_3to8.sv | 77 +++++++
 3 files changed

// File: rtl/decoder_3to8_if.sv
// decoder_3to8_if: select/enable inputs and registered one-hot Out/IDLE outputs of the decoder
interface decoder_3to8_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2 ** IN_W
);
  logic [IN_W-1:0]  In;
  logic             enable;
  logic [OUT_W-1:0] Out;
  logic             IDLE;
  modport master (output In, enable, input Out, IDLE);
  modport slave  (input In, enable, output Out, IDLE);
endinterface

// File: rtl/decoder_3to8.sv
// decoder_3to8: registered one-hot decoder; ports clk, rst (sync, active-high), bus.In/enable in, bus.Out/IDLE out
module decoder_3to8 #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2 ** IN_W
) (
  input  logic          clk,
  input  logic          rst,
  decoder_3to8_if.slave bus
);
  logic [OUT_W-1:0] out_d, out_q;
  logic             idle_d, idle_q;
  always_comb begin
    out_d  = bus.enable ? {{(OUT_W-1){1'b0}}, 1'b1} << bus.In : '0;
    idle_d = ~bus.enable;
  end
  always_ff @(posedge clk) begin
    out_q  <= rst ? '0 : out_d;
    idle_q <= rst ? 1'b1 : idle_d;
  end
  assign bus.Out  = out_q;
  assign bus.IDLE = idle_q;
endmodule

// File: tb/tb_decoder_3to8.sv
// tb_decoder_3to8: randomized scoreboard bench for decoder_3to8
module tb_decoder_3to8;
  typedef struct packed {
    logic [7:0] o;
    logic       i;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  decoder_3to8_if bus ();
  decoder_3to8 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input bit r, input bit e, input int v);
    exp_t x;
    @(negedge clk);
    rst = r;
    bus.enable = e;
    bus.In = 3'(v);
    x.o = (r || !e) ? 8'h00 : 8'(2 ** v);
    x.i = (x.o == 8'h00);
    q.push_back(x);
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        total++;
        if (bus.Out !== x.o || bus.IDLE !== x.i) begin
          bad++;
          $display("FAIL decode t=%0t: got Out=%h IDLE=%b, expected Out=%h IDLE=%b", $time, bus.Out, bus.IDLE, x.o, x.i);
        end
        total++;
        if ($countones(bus.Out) > 1 || bus.IDLE !== (bus.Out == 8'h00)) begin
          bad++;
          $display("FAIL invariant t=%0t: got Out=%h IDLE=%b, expected one-hot-or-zero with IDLE=NOR(Out)", $time, bus.Out, bus.IDLE);
        end
      end
    end
  end
  initial begin
    bus.In = 3'd0;
    bus.enable = 1'b0;
    step(1, 0, 5);
    step(1, 0, 5);
    for (int k = 0; k < 8; k++) step(0, 1, k);
    for (int k = 0; k < 10; k++) step(0, 1, int'($urandom_range(0, 7)));
    step(0, 1, 0);
    step(0, 1, 7);
    step(0, 1, 6);
    step(0, 0, 6);
    step(0, 0, 2);
    step(0, 0, 5);
    step(0, 1, 3);
    step(1, 1, 3);
    step(0, 1, 3);
    for (int k = 0; k < 60; k++)
      step(($urandom % 10) == 0, ($urandom % 3) != 0, int'($urandom_range(0, 7)));
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
